// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers for the register-array FIFOs
package fifo_pkg;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic int fifo_len_w(input int addrbit);
        return addrbit + 1;
    endfunction
endpackage

// File: rtl/fifo_fwft_flag_if.sv
// fifo_fwft_flag_if: producer/consumer side signals of the flagged FWFT FIFO
interface fifo_fwft_flag_if import fifo_pkg::*; #(parameter int ADDRBIT = 4, parameter int WIDTH = 8);
    localparam int LW = fifo_len_w(ADDRBIT);
    logic flush, fifowr, fiford, err_clr;
    logic [WIDTH-1:0] fifodin, fifodout;
    logic [LW-1:0] afull_thr, aempty_thr, fifolen, fifomax;
    logic notempty, fifofull, afull, aempty, ovf, udf;
    modport master(
        output flush, fifowr, fifodin, fiford, afull_thr, aempty_thr, err_clr,
        input fifodout, notempty, fifofull, fifolen, afull, aempty, ovf, udf, fifomax
    );
    modport slave(
        input flush, fifowr, fifodin, fiford, afull_thr, aempty_thr, err_clr,
        output fifodout, notempty, fifofull, fifolen, afull, aempty, ovf, udf, fifomax
    );
endinterface

// File: rtl/fifo_regmem.sv
// fifo_regmem: register array with sync write, async read and sync clear
module fifo_regmem #(parameter int ADDRBIT = 4, parameter int WIDTH = 8) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we,
    input  logic [ADDRBIT-1:0] waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [ADDRBIT-1:0] raddr,
    output logic [WIDTH-1:0]   rdata
);
    logic [WIDTH-1:0] mem [2**ADDRBIT];
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**ADDRBIT; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_fwft_flag.sv
// fifo_fwft_flag: show-ahead FIFO with pass-through on full, flush,
// threshold flags, sticky ovf/udf and a high-water mark
module fifo_fwft_flag import fifo_pkg::*; #(parameter int ADDRBIT = 4, parameter int WIDTH = 8) (
    input logic clk,
    input logic rst,
    fifo_fwft_flag_if.slave bus
);
    localparam int LW = fifo_len_w(ADDRBIT);
    localparam logic [LW-1:0] LENGTH = LW'(2**ADDRBIT);
    logic [ADDRBIT-1:0] wrptr, rdptr;
    logic [LW-1:0] len, len_next, fifomax;
    logic notempty, full, rd, wr, do_rd, do_wr, ovf, udf;
    assign notempty = len != '0;
    assign full = len == LENGTH;
    // rd/wr are the handshake outcome; flush then suppresses their effect
    always_comb begin
        rd = bus.fiford & notempty;
        wr = bus.fifowr & (!full | rd);
        do_rd = rd & !bus.flush;
        do_wr = wr & !bus.flush;
        len_next = bus.flush ? '0 : len + LW'(do_wr) - LW'(do_rd);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wrptr <= '0;
            rdptr <= '0;
            len <= '0;
            ovf <= 1'b0;
            udf <= 1'b0;
            fifomax <= '0;
        end else begin
            wrptr <= bus.flush ? '0 : wrptr + ADDRBIT'(do_wr);
            rdptr <= bus.flush ? '0 : rdptr + ADDRBIT'(do_rd);
            len <= len_next;
            ovf <= (bus.fifowr & full & !rd & !bus.flush) | (ovf & !bus.err_clr);
            udf <= (bus.fiford & !notempty & !bus.flush) | (udf & !bus.err_clr);
            fifomax <= (bus.err_clr || len_next > fifomax) ? len_next : fifomax;
        end
    end
    fifo_regmem #(.ADDRBIT(ADDRBIT), .WIDTH(WIDTH)) u_mem (
        .clk(clk), .rst(rst), .we(do_wr), .waddr(wrptr), .wdata(bus.fifodin),
        .raddr(rdptr), .rdata(bus.fifodout)
    );
    assign bus.notempty = notempty;
    assign bus.fifofull = full;
    assign bus.fifolen = len;
    assign bus.afull = len >= bus.afull_thr;
    assign bus.aempty = len <= bus.aempty_thr;
    assign bus.ovf = ovf;
    assign bus.udf = udf;
    assign bus.fifomax = fifomax;
endmodule

// File: tb/tb_fifo_fwft_flag.sv
// tb_fifo_fwft_flag: directed vectors plus a queue model checked every cycle
module tb_fifo_fwft_flag;
    logic clk = 0, rst = 1;
    int checks = 0, errors = 0;
    fifo_fwft_flag_if #(.ADDRBIT(4), .WIDTH(8)) bus();
    fifo_fwft_flag #(.ADDRBIT(4), .WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // model: FIFO contents as a queue, flags as plain integers
    logic [7:0] q[$];
    int m_max = 0;
    bit m_ovf = 0, m_udf = 0, armed = 0, m_r, m_w;
    int n;
    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_ovf = 0; m_udf = 0; m_max = 0; armed = 1;
        end else if (bus.flush) begin
            q.delete();
            if (bus.err_clr) begin m_ovf = 0; m_udf = 0; m_max = 0; end
        end else begin
            n = q.size();
            m_r = bus.fiford && n > 0;
            m_w = bus.fifowr && (n < 16 || m_r);
            m_ovf = (bus.fifowr && n == 16 && !m_r) || (m_ovf && !bus.err_clr);
            m_udf = (bus.fiford && n == 0) || (m_udf && !bus.err_clr);
            if (m_r) void'(q.pop_front());
            if (m_w) q.push_back(bus.fifodin);
            if (bus.err_clr || q.size() > m_max) m_max = q.size();
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("len", 32'(bus.fifolen), 32'(q.size()));
            chk("len_bound", 32'(bus.fifolen <= 16), 1);
            chk("notempty", 32'(bus.notempty), 32'(q.size() != 0));
            chk("full", 32'(bus.fifofull), 32'(q.size() == 16));
            if (q.size() != 0) chk("dout", 32'(bus.fifodout), 32'(q[0]));
            chk("afull", 32'(bus.afull), 32'(q.size() >= int'(bus.afull_thr)));
            chk("aempty", 32'(bus.aempty), 32'(q.size() <= int'(bus.aempty_thr)));
            chk("ovf", 32'(bus.ovf), 32'(m_ovf));
            chk("udf", 32'(bus.udf), 32'(m_udf));
            chk("fifomax", 32'(bus.fifomax), 32'(m_max));
        end
    end

    task automatic cyc(input bit w, input logic [7:0] d, input bit r, input bit f = 0, input bit e = 0);
        bus.fifowr = w; bus.fifodin = d; bus.fiford = r; bus.flush = f; bus.err_clr = e;
        @(posedge clk); #1;
        bus.fifowr = 0; bus.fiford = 0; bus.flush = 0; bus.err_clr = 0;
    endtask

    logic [7:0] e3 [3];
    logic [7:0] last;
    int wrote, budget;
    bit rw, rr;
    initial begin
        e3 = '{8'h11, 8'h22, 8'h33};
        bus.fifowr = 0; bus.fiford = 0; bus.flush = 0; bus.err_clr = 0; bus.fifodin = 0;
        bus.afull_thr = 5'd12; bus.aempty_thr = 5'd3;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        chk("rst_len", 32'(bus.fifolen), 0);
        chk("rst_notempty", 32'(bus.notempty), 0);
        chk("rst_dout", 32'(bus.fifodout), 0);
        chk("rst_aempty", 32'(bus.aempty), 1);
        chk("rst_afull", 32'(bus.afull), 0);
        chk("rst_max", 32'(bus.fifomax), 0);
        // basic show-ahead order
        cyc(1, 8'h11, 0);
        chk("fwft_dout", 32'(bus.fifodout), 32'h11);
        chk("fwft_notempty", 32'(bus.notempty), 1);
        cyc(1, 8'h22, 0);
        cyc(1, 8'h33, 0);
        chk("three_len", 32'(bus.fifolen), 3);
        for (int i = 0; i < 3; i++) begin
            chk("rd_order", 32'(bus.fifodout), 32'(e3[i]));
            cyc(0, 0, 1);
        end
        chk("drained", 32'(bus.notempty), 0);
        // full, overflow, pass-through
        for (int i = 0; i < 16; i++) cyc(1, 8'(i + 1), 0);
        chk("full", 32'(bus.fifofull), 1);
        cyc(1, 8'hAA, 0);
        chk("ovf_set", 32'(bus.ovf), 1);
        chk("ovf_len", 32'(bus.fifolen), 16);
        cyc(0, 0, 0, 0, 1);
        chk("ovf_clr", 32'(bus.ovf), 0);
        cyc(1, 8'hBB, 1);
        chk("rw_full_len", 32'(bus.fifolen), 16);
        chk("rw_full_ovf", 32'(bus.ovf), 0);
        chk("rw_full_head", 32'(bus.fifodout), 2);
        for (int i = 0; i < 16; i++) begin
            last = bus.fifodout;
            cyc(0, 0, 1);
        end
        chk("rw_last", 32'(last), 32'hBB);
        // underflow
        cyc(0, 0, 1);
        chk("udf_set", 32'(bus.udf), 1);
        chk("udf_len", 32'(bus.fifolen), 0);
        cyc(0, 0, 0, 0, 1);
        chk("udf_clr", 32'(bus.udf), 0);
        cyc(1, 8'h5C, 1);
        chk("rw_empty_udf", 32'(bus.udf), 1);
        chk("rw_empty_len", 32'(bus.fifolen), 1);
        chk("rw_empty_dout", 32'(bus.fifodout), 32'h5C);
        cyc(0, 0, 0, 0, 1);
        chk("udf_clr2", 32'(bus.udf), 0);
        cyc(0, 0, 1);
        // thresholds
        cyc(0, 0, 0, 0, 1);
        for (int i = 1; i <= 12; i++) begin
            cyc(1, 8'(i), 0);
            if (i == 3) chk("aempty_at3", 32'(bus.aempty), 1);
            if (i == 4) chk("aempty_at4", 32'(bus.aempty), 0);
            if (i == 11) chk("afull_at11", 32'(bus.afull), 0);
            if (i == 12) chk("afull_at12", 32'(bus.afull), 1);
        end
        for (int i = 0; i < 9; i++) cyc(0, 0, 1);
        chk("drain3_len", 32'(bus.fifolen), 3);
        chk("drain3_aempty", 32'(bus.aempty), 1);
        // flush and high-water mark
        cyc(0, 0, 0, 1, 1);
        chk("flush_clr_max", 32'(bus.fifomax), 0);
        for (int i = 0; i < 9; i++) cyc(1, 8'(i + 8'h40), 0);
        cyc(1, 8'hEE, 0, 1);
        chk("flush_len", 32'(bus.fifolen), 0);
        chk("flush_notempty", 32'(bus.notempty), 0);
        chk("flush_max", 32'(bus.fifomax), 9);
        cyc(0, 0, 0, 0, 1);
        chk("max_clr", 32'(bus.fifomax), 0);
        // threshold extremes
        bus.afull_thr = 5'd0; #1;
        chk("afull_thr0", 32'(bus.afull), 1);
        for (int i = 0; i < 3; i++) cyc(1, 8'(i + 8'h70), 0);
        bus.afull_thr = 5'd17; #1;
        chk("afull_thr17", 32'(bus.afull), 0);
        bus.afull_thr = 5'd3; #1;
        chk("afull_thr3", 32'(bus.afull), 1);
        bus.afull_thr = 5'd12;
        // reset mid-operation beats flush and err_clr
        bus.flush = 1; bus.err_clr = 1; bus.fifowr = 1; bus.fifodin = 8'h99; rst = 1;
        @(posedge clk); #1;
        rst = 0; bus.flush = 0; bus.err_clr = 0; bus.fifowr = 0;
        chk("midrst_len", 32'(bus.fifolen), 0);
        chk("midrst_dout", 32'(bus.fifodout), 0);
        chk("midrst_max", 32'(bus.fifomax), 0);
        // random traffic with wrap-around
        wrote = 0; budget = 0;
        while (wrote < 40 && budget < 1000) begin
            rw = ($urandom_range(0, 3) != 0);
            rr = ($urandom_range(0, 2) == 0);
            if (rw && (q.size() < 16 || (rr && q.size() > 0))) begin
                cyc(1, 8'(wrote + 8'h80), rr);
                wrote++;
            end else cyc(0, 0, rr);
            budget++;
        end
        chk("rand_written", 32'(wrote), 40);
        budget = 0;
        while (q.size() > 0 && budget < 40) begin
            cyc(0, 0, 1);
            budget++;
        end
        chk("rand_drained", 32'(bus.fifolen), 0);
        @(posedge clk); #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
